online_to_conv_r4: RTL and testbench
====================================

// Module: online_to_conv_r4
// PURPOSE
//  Radix-4 on-the-fly converter. Consumes the MSD-first signed-digit stream (digits -3..+3)
//  produced by the radix-4 online adder. Assembles an N-digit operand into a conventional
//  two's-complement integer using Q/QM registers, so there is no carry-propagate adder.
//  Sits directly downstream of the adder; its zi output connects straight to this block's zi.
// PARAMETERS
//  N   8   digits per operand (N >= 1); result value = sum d_j * 4^(N-j), j = 1..N
//  W   2*N+1   result width (derived localparam; not to be overridden)
// PORTS
//  clk      in   1   clock, rising edge
//  reset_n  in   1   asynchronous, active-low reset
//  en       in   1   digit strobe: zi is consumed on this edge when en = 1
//  start    in   1   with en: zi is digit 1 of a new operand
//  zi       in   3   signed digit, two's complement, legal range -3..+3
//  busy     out  1   1 while an operand is partially assembled
//  done     out  1   one-cycle pulse: result has just been updated
//  result   out  W   signed converted value; held until the next completion
//  digit_err out 1   sticky illegal-digit flag (OTF_DIGIT_CHECK_EN only; else constant 0)
// BEHAVIOUR
//  - Reset (async, reset_n = 0): state = IDLE, busy = 0, done = 0, result = 0,
//    digit_err = 0, digit count = 0, Q = 0, QM = all ones (-1).
//  - States:
//    - IDLE: en & start -> load digit 1; go to CONV (or complete immediately if N = 1).
//      en without start is ignored.
//    - CONV: each en consumes one digit. The Nth digit -> result <= Q', done = 1
//      for one cycle, then IDLE. en = 0 holds all state.
//  - Restart: en & start in CONV aborts the current operand, with no done.
//    zi on that edge is digit 1 of the new operand.
//  - Back-to-back operands: start may be accepted in the cycle right after the Nth digit
//    (zero bubble).
//  - Per accepted digit d, with Q, QM W bits wide and a 2-bit left shift:
//      Q'  = (d >= 0) ? {Q[W-3:0],  d[1:0]}       : {QM[W-3:0], (d+4)[1:0]}
//      QM' = (d >  0) ? {Q[W-3:0], (d-1)[1:0]}    : {QM[W-3:0], (d+3)[1:0]}
//    - Invariant: QM = Q - 1.
//    - On start, Q/QM restart from 0 / -1 before the update.
//    - Only 2-bit digit arithmetic is used; no W-bit adder.
//  - Latency: done and result are registered on the edge that consumes digit N.
//    Visible in the following cycle.
//  - busy = (state == CONV).
//  - Range: |result| <= 4^N - 1, which always fits in W bits with no overflow.
//  - zi = -4 (3'b100) is illegal. Without the check feature the behaviour is undefined.
// CONFIGURATION
//  OTF_DIGIT_CHECK_EN defined:
//    - Any accepted digit equal to -4 sets digit_err.
//    - digit_err is sticky until reset_n.
//    - The digit is still processed as the unsigned 2-bit pattern.
//  OTF_DIGIT_CHECK_EN undefined: digit_err is tied to 0 and there is no check logic.
// TESTING (N = 4)
//  1. Digits 1,2,-1,3 with en each cycle, start on the first -> done 1 cycle after the last;
//     result = 95.
//  2. Digits -3,0,0,0 -> result = -192.
//     Digits 3,3,3,3 -> result = 255.
//     Digits -3,-3,-3,-3 -> result = -255.
//  3. Digits 1,2 (start), then start with 2,0,0,1 -> only one done pulse; result = 129;
//     the first operand is aborted.
//  4. en low for 3 cycles between digits 2 and 3 of case 1 -> result still 95;
//     busy stays 1 throughout.
//  5. Reset asserted after digit 2 -> busy, done, result = 0 immediately.
//     A new 4-digit operand then converts correctly.
//  6. OTF_DIGIT_CHECK_EN: digit -4 mid-operand -> digit_err = 1 from the next cycle,
//     persisting across the following operand.

Source files
------------

// File: rtl/online_to_conv_r4.sv
// Radix-4 on-the-fly converter: MSD-first signed digits (-3..+3) to a two's-complement integer via Q/QM registers.
// Optional build macro OTF_DIGIT_CHECK_EN adds a sticky flag for the illegal digit -4.
module online_to_conv_r4 #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           start,
    input  logic [2:0]     zi,
    output logic           busy,
    output logic           done,
    output logic [2*N:0]   result,
    output logic           digit_err
);

    // state | meaning
    // IDLE  | no operand in progress; en & start loads digit 1
    // CONV  | operand partially assembled; each en consumes one digit
    typedef enum logic {IDLE, CONV} state_t;

    localparam int W  = 2*N + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t          state;
    logic [CW-1:0]   rem;
    logic [W-1:0]    q, qm;
    logic [W-1:0]    q_base, qm_base, q_next, qm_next;
    logic [1:0]      d_minus1;
    logic            accept, last;

    // On start the registers restart from 0 / -1 before the digit is appended.
    // Digit arithmetic is only 2 bits wide: (d+4) mod 4 == d mod 4 and (d+3) mod 4 == (d-1) mod 4.
    always_comb begin
        q_base   = start ? '0 : q;
        qm_base  = start ? '1 : qm;
        d_minus1 = zi[1:0] - 2'd1;
        q_next   = (zi[2] ? (qm_base << 2) : (q_base << 2)) | W'(zi[1:0]);
        qm_next  = ((!zi[2] && (zi[1:0] != 2'd0)) ? (q_base << 2) : (qm_base << 2)) | W'(d_minus1);
        accept   = en && (start || (state == CONV));
        last     = start ? (N == 1) : (rem == CW'(1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rem    <= '0;
            q      <= '0;
            qm     <= '1;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                q  <= q_next;
                qm <= qm_next;
                if (last) begin
                    result <= q_next;
                    done   <= 1'b1;
                    state  <= IDLE;
                    rem    <= '0;
                end else begin
                    state <= CONV;
                    rem   <= start ? CW'(N - 1) : (rem - CW'(1));
                end
            end
        end
    end

    assign busy = (state == CONV);

`ifdef OTF_DIGIT_CHECK_EN
    // Sticky until reset; the offending digit is still converted from its low two bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digit_err <= 1'b0;
        end else if (accept && (zi == 3'b100)) begin
            digit_err <= 1'b1;
        end
    end
`else
    assign digit_err = 1'b0;
`endif

endmodule

// File: tb/tb_online_to_conv_r4.sv
// Scoreboard bench for online_to_conv_r4 (N = 4): directed operands plus randomized digit streams.
module tb_online_to_conv_r4;

    localparam int N = 4;
    localparam int W = 2*N + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    zi = 3'd0;
    logic          busy, done, digit_err;
    logic [W-1:0]  result;

    online_to_conv_r4 #(.N(N)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .start     (start),
        .zi        (zi),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .digit_err (digit_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int val;
        bit chk;
        int due;
    } exp_t;
    exp_t exp_q[$];

    int n_chk = 0;
    int n_fail = 0;

    // operand-level reference model
    int pos = 0;
    int acc = 0;
    bit op_bad = 0;
    bit exp_busy = 0;
    bit err_exp = 0;
    int exp_result = 0;
    bit res_known = 1;
    bit use_ovr = 0;
    int ovr_val = 0;

    function automatic void check(string name, int act, int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    task automatic drive_digit(input bit s, input int d);
        bit accepted;
        exp_t e;
        en = 1'b1;
        start = s;
        zi = d[2:0];
        @(posedge clk);
        #1;
        en = 1'b0;
        start = 1'b0;
        zi = 3'($urandom);
        accepted = s || (pos > 0);
        if (s) begin
            pos = 1;
            acc = d;
            op_bad = (d == -4);
        end else if (pos > 0) begin
            pos++;
            acc = acc * 4 + d;
            if (d == -4) op_bad = 1;
        end
`ifdef OTF_DIGIT_CHECK_EN
        if (accepted && d == -4) err_exp = 1;
`else
        if (accepted && d == -4) op_bad = 1;
`endif
        if (pos == N) begin
            e.val = use_ovr ? ovr_val : acc;
            e.chk = !op_bad;
            e.due = cyc;
            exp_q.push_back(e);
            pos = 0;
        end
        exp_busy = (pos > 0);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) begin
            start = 1'($urandom);
            zi = 3'($urandom);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic op4(input int expv, input int d0, input int d1, input int d2, input int d3);
        use_ovr = 1;
        ovr_val = expv;
        drive_digit(1, d0);
        drive_digit(0, d1);
        drive_digit(0, d2);
        drive_digit(0, d3);
        use_ovr = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_result", $signed(result), 0);
        end else begin
            check("busy", busy, exp_busy);
            check("digit_err", digit_err, err_exp);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("done_spurious", done, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e.due);
                    if (e.chk) begin
                        check("result", $signed(result), e.val);
                        exp_result = e.val;
                        res_known = 1;
                    end else begin
                        res_known = 0;
                    end
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    check("done_missing", done, 1);
                    void'(exp_q.pop_front());
                end
                if (res_known) check("result_hold", $signed(result), exp_result);
            end
        end
    end

    initial begin
        int r;
        int d;
        bit s;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // case 1 followed back-to-back (zero bubble) by case 2a
        op4(95, 1, 2, -1, 3);
        op4(-192, -3, 0, 0, 0);
        idle(1);
        op4(255, 3, 3, 3, 3);
        op4(-255, -3, -3, -3, -3);
        idle(2);

        // restart mid-operand: only the second operand completes
        drive_digit(1, 1);
        drive_digit(0, 2);
        op4(129, 2, 0, 0, 1);
        idle(2);

        // en gap between digits 2 and 3
        use_ovr = 1;
        ovr_val = 95;
        drive_digit(1, 1);
        drive_digit(0, 2);
        idle(3);
        drive_digit(0, -1);
        drive_digit(0, 3);
        use_ovr = 0;
        idle(2);

        // async reset mid-operand
        drive_digit(1, 1);
        drive_digit(0, 2);
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_result", $signed(result), 0);
        check("async_rst_err", digit_err, 0);
        pos = 0;
        exp_busy = 0;
        err_exp = 0;
        exp_q.delete();
        exp_result = 0;
        res_known = 1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(1);
        op4(95, 1, 2, -1, 3);
        idle(1);

`ifdef OTF_DIGIT_CHECK_EN
        drive_digit(1, 1);
        drive_digit(0, -4);
        drive_digit(0, 0);
        drive_digit(0, 0);
        idle(1);
        op4(95, 1, 2, -1, 3);
        idle(1);
`endif

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                idle(1);
            end else begin
                s = (pos == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
                d = $urandom_range(0, 6);
                drive_digit(s, d - 3);
            end
        end

        idle(1);
        repeat (6) @(negedge clk);
        #1;
        check("drain", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
